imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 29 ++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader/pipeline definitions: loader state encoding, instruction-memory
// geometry defaults and the ceiling a one-byte word-count header can express.
package imem_loader_pkg;

    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned IMEM_AW    = 6;
    localparam int unsigned LD_HDR_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: big-endian 4-byte word assembler; word is the full word that
// results if byte_in is shifted in this cycle, last flags the 4th byte.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= {sr[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

    assign word = {sr, byte_in};
    assign last = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: serial program-stream loader that writes 32-bit words into the
// instruction memory. Optional macro LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned AW    = IMEM_AW
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    input  logic          LD_start,
    input  logic          LD_byte_valid,
    input  logic [7:0]    LD_byte,
    output logic          LD_byte_ready,
    output logic          IMEM_wr_en,
    output logic [AW-1:0] IMEM_addr,
    output logic [31:0]   IMEM_data,
    output logic          LD_busy,
    output logic          LD_done,
    output logic          LD_error
);

    localparam int unsigned N_LIMIT = (DEPTH < LD_HDR_MAX) ? DEPTH : LD_HDR_MAX;

    ld_state_t     state, nxt;
    logic [AW:0]   word_idx, idx_inc, n_words;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic          error_q;
    logic          start_ok, xfer, hdr_bad;
    logic          pk_shift, pk_last;
    logic [31:0]   pk_word;

    assign start_ok      = (state == ST_IDLE) && LD_start;
    assign LD_byte_ready = (state == ST_HEADER) || (state == ST_DATA) || (state == ST_CHECK);
    assign xfer          = LD_byte_valid && LD_byte_ready;
    assign pk_shift      = xfer && (state == ST_DATA);
    assign hdr_bad       = (LD_byte == 8'd0) || (32'(LD_byte) > N_LIMIT);
    assign idx_inc       = word_idx + 1'b1;

    byte_packer u_packer (
        .clk      (SYS_clk),
        .reset    (SYS_reset),
        .clear    (start_ok),
        .shift_en (pk_shift),
        .byte_in  (LD_byte),
        .word     (pk_word),
        .last     (pk_last)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset || start_ok) begin
            csum <= '0;
        end else if (pk_shift) begin
            csum <= csum ^ LD_byte;
        end
    end
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:   if (LD_start) nxt = ST_HEADER;
            ST_HEADER: if (xfer) nxt = hdr_bad ? ST_ERROR : ST_DATA;
            ST_DATA:   if (pk_shift && pk_last) nxt = ST_WRITE;
            ST_WRITE: begin
                if (idx_inc < n_words) begin
                    nxt = ST_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    nxt = ST_CHECK;
`else
                    nxt = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) nxt = (LD_byte == csum) ? ST_DONE : ST_ERROR;
`else
                nxt = ST_IDLE;
`endif
            end
            ST_DONE:   nxt = ST_IDLE;
            ST_ERROR:  nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    // Address/data are captured with the 4th byte so they are valid in the
    // WRITE cycle and hold afterwards, independent of the index increment.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            n_words  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (start_ok) begin
                word_idx <= '0;
                error_q  <= 1'b0;
            end
            if ((state == ST_HEADER) && xfer) n_words <= (AW+1)'(LD_byte);
            if (pk_shift && pk_last) begin
                addr_q <= word_idx[AW-1:0];
                data_q <= pk_word;
            end
            if (state == ST_WRITE) word_idx <= idx_inc;
            if (nxt == ST_ERROR) error_q <= 1'b1;
        end
    end

    assign IMEM_wr_en = (state == ST_WRITE);
    assign IMEM_addr  = addr_q;
    assign IMEM_data  = data_q;
    assign LD_busy    = (state != ST_IDLE);
    assign LD_done    = (state == ST_DONE);
    assign LD_error   = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; each scenario task checks its own results.
// Checksum bytes are appended to streams when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  byte_d = '0;
    logic        ready, wr_en, busy, done, error;
    logic [5:0]  addr;
    logic [31:0] data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    int done_cnt = 0;
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          lat_q[$];

    imem_loader #(.DEPTH(64), .AW(6)) dut (
        .SYS_clk       (clk),
        .SYS_reset     (reset),
        .LD_start      (start),
        .LD_byte_valid (valid),
        .LD_byte       (byte_d),
        .LD_byte_ready (ready),
        .IMEM_wr_en    (wr_en),
        .IMEM_addr     (addr),
        .IMEM_data     (data),
        .LD_busy       (busy),
        .LD_done       (done),
        .LD_error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(addr);
            wd_q.push_back(data);
            lat_q.push_back(cyc - last_acc);
        end
        if (valid && ready) last_acc = cyc;
        if (done) done_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        lat_q.delete();
        done_cnt = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        byte_d = b;
        valid  = 1'b1;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: byte %h never accepted", b);
        end
        tick(1);
        valid = 1'b0;
        if (gap) tick(1);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gap);
        logic [7:0] x = '0;
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gap);
            if (i > 0) x ^= s[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        if ({ready, wr_en, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {ready, wr_en, busy, done, error});
        end
        checks++;
        if (addr !== 6'd0 || data !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h/%h want 00/00000000", addr, data);
        end
        checks++;
    endtask

    task automatic test_single_word();
        clear_log();
        pulse_start();
        if (busy !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_ready: got %b%b want 11", busy, ready);
        end
        checks++;
        send_stream('{8'h01, 8'h20, 8'h08, 8'h00, 8'h05}, 1'b0);
        tick(4);
        if (wa_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes want 1", wa_q.size());
        end else begin
            if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h20080005) begin
                errors++;
                $display("FAIL single_write: got %h/%h want 00/20080005", wa_q[0], wd_q[0]);
            end
            checks++;
            if (lat_q[0] != 1) begin
                errors++;
                $display("FAIL single_latency: got %0d want 1", lat_q[0]);
            end
        end
        checks++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%0d err=%b busy=%b want 1/0/0", done_cnt, error, busy);
        end
        checks++;
        if (addr !== 6'd0 || data !== 32'h20080005) begin
            errors++;
            $display("FAIL single_hold: got %h/%h want 00/20080005", addr, data);
        end
        checks++;
    endtask

    task automatic test_gapped_stream();
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        pulse_start();  // must be ignored mid-session
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        tick(4);
        if (wa_q.size() != 2) begin
            errors++;
            $display("FAIL gapped_count: got %0d writes want 2", wa_q.size());
        end else begin
            if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h00000000) begin
                errors++;
                $display("FAIL gapped_w0: got %h/%h want 00/00000000", wa_q[0], wd_q[0]);
            end
            checks++;
            if (wa_q[1] !== 6'd1 || wd_q[1] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL gapped_w1: got %h/%h want 01/ffffffff", wa_q[1], wd_q[1]);
            end
            checks++;
            if (lat_q[0] != 1 || lat_q[1] != 1) begin
                errors++;
                $display("FAIL gapped_latency: got %0d,%0d want 1,1", lat_q[0], lat_q[1]);
            end
        end
        checks++;
        if (done_cnt != 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL gapped_done: got done=%0d err=%b want 1/0", done_cnt, error);
        end
        checks++;
        if (addr !== 6'd1 || data !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL gapped_hold: got %h/%h want 01/ffffffff", addr, data);
        end
        checks++;
    endtask

    task automatic test_bad_header(input logic [7:0] hdr);
        clear_log();
        pulse_start();
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL hdr_start_clears: hdr %h got err=%b want 0", hdr, error);
        end
        checks++;
        send_byte(hdr, 1'b0);
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL hdr_error: hdr %h got err=%b want 1", hdr, error);
        end
        checks++;
        tick(2);
        if (busy !== 1'b0 || error !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL hdr_idle: hdr %h got busy=%b err=%b rdy=%b want 0/1/0", hdr, busy, error, ready);
        end
        checks++;
        if (wa_q.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL hdr_no_write: hdr %h got writes=%0d done=%0d want 0/0", hdr, wa_q.size(), done_cnt);
        end
        checks++;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h00, 1'b0);
        tick(3);
        if (wa_q.size() != 1 || wd_q[0] !== 32'h11223344) begin
            errors++;
            $display("FAIL csum_write: got %0d writes want 1 of 11223344", wa_q.size());
        end
        checks++;
        if (error !== 1'b1 || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_error: got err=%b done=%0d busy=%b want 1/0/0", error, done_cnt, busy);
        end
        checks++;
    endtask
`endif

    task automatic test_mid_reset();
        clear_log();
        pulse_start();
        send_stream('{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11}, 1'b0);
        send_byte(8'h22, 1'b0);
        reset  = 1'b1;
        start  = 1'b1;
        valid  = 1'b1;
        byte_d = 8'h33;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        if ({ready, wr_en, busy, done, error} !== 5'b0 || addr !== 6'd0 || data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got flags=%b addr=%h data=%h want 0/00/00000000",
                     {ready, wr_en, busy, done, error}, addr, data);
        end
        checks++;
        tick(6);
        if (wa_q.size() != 1 || wd_q[0] !== 32'hAABBCCDD || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes busy=%b want 1 (aabbccdd) busy=0", wa_q.size(), busy);
        end
        checks++;
        clear_log();
        pulse_start();
        send_stream('{8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);
        tick(4);
        if (wa_q.size() != 1 || wa_q[0] !== 6'd0 || wd_q[0] !== 32'h12345678 || done_cnt != 1) begin
            errors++;
            $display("FAIL midreset_fresh: got writes=%0d done=%0d want one 00/12345678 and done", wa_q.size(), done_cnt);
        end
        checks++;
    endtask

    task automatic test_full_depth();
        logic [7:0]  s[$];
        logic [31:0] w;
        int bad = 0;
        clear_log();
        s.push_back(8'h40);
        for (int i = 0; i < 64; i++) begin
            w = {i[7:0], 8'hA5, ~i[7:0], 8'(i * 3)};
            s.push_back(w[31:24]);
            s.push_back(w[23:16]);
            s.push_back(w[15:8]);
            s.push_back(w[7:0]);
        end
        pulse_start();
        send_stream(s, 1'b0);
        tick(4);
        if (wa_q.size() != 64) begin
            errors++;
            $display("FAIL full_count: got %0d writes want 64", wa_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                w = {i[7:0], 8'hA5, ~i[7:0], 8'(i * 3)};
                if (wa_q[i] !== 6'(i) || wd_q[i] !== w || lat_q[i] != 1) begin
                    bad++;
                    if (bad <= 4)
                        $display("FAIL full_word%0d: got %h/%h lat=%0d want %h/%h lat=1",
                                 i, wa_q[i], wd_q[i], lat_q[i], 6'(i), w);
                end
            end
            if (bad != 0) errors++;
        end
        checks++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got done=%0d err=%b busy=%b want 1/0/0", done_cnt, error, busy);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gapped_stream();
        test_bad_header(8'h00);
        test_bad_header(8'h41);
`ifdef LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_mid_reset();
        test_full_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
